// File: rtl/ulpi_phy_emu.sv
// rtl/ulpi_phy_emu.sv - PHY-side ULPI responder with register file, TX capture and RX injection
module ulpi_phy_emu #(
   parameter int REG_COUNT      = 16,
   parameter int TX_STALL_EVERY = 0
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] ulpi_data_in_i,
   output logic [7:0] ulpi_data_out_o,
   output logic       ulpi_dir_o,
   output logic       ulpi_nxt_o,
   input  logic       ulpi_stp_i,
   input  logic [1:0] linestate_i,
   input  logic [7:0] inj_data_i,
   input  logic       inj_valid_i,
   input  logic       inj_last_i,
   output logic       inj_ready_o,
   output logic [7:0] cap_data_o,
   output logic       cap_valid_o,
   output logic       cap_last_o
);

   localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_TX,
      S_REGW_CMD,
      S_REGW_DATA,
      S_REGW_STP,
      S_REGR_ACC,
      S_REGR_TA,
      S_REGR_DAT,
      S_RXC_TA,
      S_RXC_DAT,
      S_RX_DATA,
      S_RX_LAST,
      S_TA_END
   } state_t;

   state_t      state;
   logic [7:0]  regs [REG_COUNT];
   logic [5:0]  reg_addr;
   logic [7:0]  wr_data;
   logic [7:0]  pend_data;
   logic        pend_valid;
   logic        first_byte;
   logic [15:0] stall_cnt;
   logic [1:0]  last_ls;

   logic        cmd_tx;
   logic        cmd_regw;
   logic        cmd_regr;
   logic        addr_ok;
   logic [7:0]  rd_val;
   logic [7:0]  rxcmd_act;
   logic [7:0]  rxcmd_idle;

   // Decode the link command byte, select the addressed register, build RX CMD bytes
   always_comb begin
      cmd_tx     = (ulpi_data_in_i[7:4] == 4'b0100);
      cmd_regw   = (ulpi_data_in_i[7:6] == 2'b10);
      cmd_regr   = (ulpi_data_in_i[7:6] == 2'b11);
      addr_ok    = (int'(reg_addr) < REG_COUNT);
      rd_val     = addr_ok ? regs[reg_addr[AW-1:0]] : 8'h00;
      rxcmd_act  = {2'b00, 2'b01, 2'b00, linestate_i};
      rxcmd_idle = {2'b00, 2'b00, 2'b00, linestate_i};
   end

   // Bus ownership FSM: every ULPI and side-band output is registered here
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state           <= S_IDLE;
         ulpi_dir_o      <= 1'b0;
         ulpi_nxt_o      <= 1'b0;
         ulpi_data_out_o <= 8'h00;
         inj_ready_o     <= 1'b0;
         cap_valid_o     <= 1'b0;
         cap_last_o      <= 1'b0;
         cap_data_o      <= 8'h00;
         pend_data       <= 8'h00;
         pend_valid      <= 1'b0;
         first_byte      <= 1'b0;
         stall_cnt       <= 16'd0;
         reg_addr        <= 6'd0;
         wr_data         <= 8'h00;
         last_ls         <= linestate_i;
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= 8'h00;
      end else begin
         cap_valid_o <= 1'b0;
         cap_last_o  <= 1'b0;
         inj_ready_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (ulpi_data_in_i != 8'h00 && !ulpi_stp_i) begin
                  reg_addr <= ulpi_data_in_i[5:0];
                  if (cmd_tx) begin
                     ulpi_nxt_o <= 1'b1;
                     first_byte <= 1'b1;
                     pend_valid <= 1'b0;
                     stall_cnt  <= 16'd0;
                     state      <= S_TX;
                  end else if (cmd_regw) begin
                     ulpi_nxt_o <= 1'b1;
                     state      <= S_REGW_CMD;
                  end else if (cmd_regr) begin
                     ulpi_nxt_o <= 1'b1;
                     state      <= S_REGR_ACC;
                  end
               end else if (ulpi_data_in_i == 8'h00 && inj_valid_i) begin
                  ulpi_dir_o      <= 1'b1;
                  ulpi_nxt_o      <= 1'b1;
                  ulpi_data_out_o <= 8'h00;
                  state           <= S_RX_DATA;
               end else if (ulpi_data_in_i == 8'h00 && linestate_i != last_ls) begin
                  ulpi_dir_o      <= 1'b1;
                  ulpi_nxt_o      <= 1'b0;
                  ulpi_data_out_o <= 8'h00;
                  last_ls         <= linestate_i;
                  state           <= S_RXC_TA;
               end
            end
            S_TX: begin
               // Bytes are held one cycle so the final one can carry cap_last when stp arrives
               if (ulpi_stp_i) begin
                  cap_valid_o <= pend_valid;
                  cap_last_o  <= pend_valid;
                  cap_data_o  <= pend_data;
                  pend_valid  <= 1'b0;
                  ulpi_nxt_o  <= 1'b0;
                  state       <= S_IDLE;
               end else if (ulpi_nxt_o) begin
                  cap_valid_o <= pend_valid;
                  cap_data_o  <= pend_data;
                  pend_data   <= ulpi_data_in_i;
                  pend_valid  <= 1'b1;
                  first_byte  <= 1'b0;
                  if (TX_STALL_EVERY > 0 && !first_byte) begin
                     if (stall_cnt == 16'(TX_STALL_EVERY - 1)) begin
                        stall_cnt  <= 16'd0;
                        ulpi_nxt_o <= 1'b0;
                     end else begin
                        stall_cnt <= stall_cnt + 16'd1;
                     end
                  end
               end else begin
                  ulpi_nxt_o <= 1'b1;
               end
            end
            S_REGW_CMD: begin
               if (ulpi_stp_i) begin
                  ulpi_nxt_o <= 1'b0;
                  state      <= S_IDLE;
               end else begin
                  state <= S_REGW_DATA;
               end
            end
            S_REGW_DATA: begin
               ulpi_nxt_o <= 1'b0;
               if (ulpi_stp_i) begin
                  state <= S_IDLE;
               end else begin
                  wr_data <= ulpi_data_in_i;
                  state   <= S_REGW_STP;
               end
            end
            S_REGW_STP: begin
               if (ulpi_stp_i && addr_ok) regs[reg_addr[AW-1:0]] <= wr_data;
               state <= S_IDLE;
            end
            S_REGR_ACC: begin
               ulpi_nxt_o      <= 1'b0;
               ulpi_dir_o      <= 1'b1;
               ulpi_data_out_o <= 8'h00;
               state           <= S_REGR_TA;
            end
            S_REGR_TA: begin
               ulpi_data_out_o <= rd_val;
               state           <= S_REGR_DAT;
            end
            S_REGR_DAT, S_RXC_DAT: begin
               ulpi_data_out_o <= 8'h00;
               state           <= S_TA_END;
            end
            S_RXC_TA: begin
               ulpi_data_out_o <= {6'b000000, last_ls};
               state           <= S_RXC_DAT;
            end
            S_RX_DATA: begin
               if (inj_valid_i) begin
                  ulpi_data_out_o <= inj_data_i;
                  ulpi_nxt_o      <= 1'b1;
                  inj_ready_o     <= 1'b1;
                  if (inj_last_i) state <= S_RX_LAST;
               end else begin
                  ulpi_nxt_o      <= 1'b0;
                  ulpi_data_out_o <= rxcmd_act;
               end
            end
            S_RX_LAST: begin
               ulpi_nxt_o      <= 1'b0;
               ulpi_data_out_o <= rxcmd_idle;
               state           <= S_RXC_DAT;
            end
            S_TA_END: begin
               ulpi_dir_o      <= 1'b0;
               ulpi_data_out_o <= 8'h00;
               state           <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ulpi_phy_emu.sv
// tb/tb_ulpi_phy_emu.sv - scoreboard bench for ulpi_phy_emu
module tb_ulpi_phy_emu;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic [7:0] ulpi_data_in_i = 8'h00;
   logic [7:0] ulpi_data_out_o;
   logic       ulpi_dir_o;
   logic       ulpi_nxt_o;
   logic       ulpi_stp_i = 1'b0;
   logic [1:0] linestate_i = 2'b01;
   logic [7:0] inj_data_i = 8'h00;
   logic       inj_valid_i = 1'b0;
   logic       inj_last_i = 1'b0;
   logic       inj_ready_o;
   logic [7:0] cap_data_o;
   logic       cap_valid_o;
   logic       cap_last_o;

   always #5 clk_i = ~clk_i;

   ulpi_phy_emu #(.REG_COUNT(16), .TX_STALL_EVERY(2)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .ulpi_data_in_i  (ulpi_data_in_i),
      .ulpi_data_out_o (ulpi_data_out_o),
      .ulpi_dir_o      (ulpi_dir_o),
      .ulpi_nxt_o      (ulpi_nxt_o),
      .ulpi_stp_i      (ulpi_stp_i),
      .linestate_i     (linestate_i),
      .inj_data_i      (inj_data_i),
      .inj_valid_i     (inj_valid_i),
      .inj_last_i      (inj_last_i),
      .inj_ready_o     (inj_ready_o),
      .cap_data_o      (cap_data_o),
      .cap_valid_o     (cap_valid_o),
      .cap_last_o      (cap_last_o)
   );

   int         n_checks = 0;
   int         n_pass = 0;
   logic [8:0] exp_cap [$];
   logic [7:0] exp_rx [$];
   int         low_at [$];
   int         dir_cnt = 0;
   int         rdy_cnt = 0;
   logic       prev_dir = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Output monitor: captured TX bytes and PHY->link packet bytes against the scoreboards
   always @(negedge clk_i) begin
      logic [8:0] ec;
      logic [7:0] er;
      if (cap_valid_o) begin
         if (exp_cap.size() == 0) chk("cap_queue_nonempty", exp_cap.size(), 1);
         else begin
            ec = exp_cap.pop_front();
            chk("cap_byte", {cap_last_o, cap_data_o}, ec);
         end
      end
      if (ulpi_dir_o && prev_dir && ulpi_nxt_o) begin
         if (exp_rx.size() == 0) chk("rx_queue_nonempty", exp_rx.size(), 1);
         else begin
            er = exp_rx.pop_front();
            chk("rx_byte", ulpi_data_out_o, er);
         end
      end
      if (ulpi_dir_o) dir_cnt++;
      if (inj_ready_o) rdy_cnt++;
      prev_dir = ulpi_dir_o;
   end

   // Link side: present each byte until nxt accepts it, then pulse stp
   task automatic link_write(input logic [7:0] b [8], input int n, output int nxt_hi);
      int   idx;
      int   guard;
      logic n_s;
      idx = 0;
      guard = 0;
      nxt_hi = 0;
      low_at.delete();
      ulpi_data_in_i = b[0];
      while (idx < n && guard < 50) begin
         @(negedge clk_i);
         n_s = ulpi_nxt_o;
         if (n_s) nxt_hi++;
         else if (idx > 0) low_at.push_back(idx);
         tick();
         guard++;
         if (n_s) idx++;
         ulpi_data_in_i = (idx < n) ? b[idx] : 8'h00;
      end
      chk("link_accept_count", idx, n);
      ulpi_stp_i = 1'b1;
      tick();
      ulpi_stp_i = 1'b0;
   endtask

   task automatic regr(input logic [7:0] cmd, output logic [7:0] rd, output int dirs);
      ulpi_data_in_i = cmd;
      tick();
      chk("regr_nxt", ulpi_nxt_o, 1);
      dirs = 0;
      rd = 8'h00;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 0) ulpi_data_in_i = 8'h00;
         if (ulpi_dir_o) dirs++;
         if (i == 1) rd = ulpi_data_out_o;
      end
   endtask

   task automatic rxcmd_obs(input logic [7:0] exp_byte);
      int g;
      g = 0;
      while (!ulpi_dir_o && g < 6) begin
         tick();
         g++;
      end
      chk("rxcmd_ta", {ulpi_dir_o, ulpi_nxt_o}, 2'b10);
      tick();
      chk("rxcmd_byte", {ulpi_dir_o, ulpi_data_out_o}, {1'b1, exp_byte});
      tick();
      chk("rxcmd_tail_dir", ulpi_dir_o, 1);
      tick();
      chk("rxcmd_release", ulpi_dir_o, 0);
   endtask

   task automatic inject(input logic [7:0] b [4], input int n, input int gap_at, input logic [1:0] ls);
      int idx;
      int g;
      idx = 0;
      g = 0;
      for (int i = 0; i < n; i++) exp_rx.push_back(b[i]);
      dir_cnt = 0;
      rdy_cnt = 0;
      inj_data_i = b[0];
      inj_last_i = (n == 1);
      inj_valid_i = 1'b1;
      while (idx < n && g < 40) begin
         tick();
         g++;
         if (inj_ready_o) begin
            idx++;
            if (idx == gap_at) begin
               inj_valid_i = 1'b0;
               tick();
               g++;
               chk("gap_rxcmd", {ulpi_dir_o, ulpi_nxt_o, ulpi_data_out_o}, {2'b10, 4'h1, 2'b00, ls});
            end
            if (idx < n) begin
               inj_data_i = b[idx];
               inj_last_i = (idx == n - 1);
               inj_valid_i = 1'b1;
            end else begin
               inj_valid_i = 1'b0;
               inj_last_i = 1'b0;
            end
         end
      end
      chk("inj_consumed", idx, n);
      tick();
      chk("rx_end_rxcmd", {ulpi_dir_o, ulpi_nxt_o, ulpi_data_out_o}, {2'b10, 6'b000000, ls});
      tick();
      chk("rx_tail_dir", ulpi_dir_o, 1);
      tick();
      chk("rx_release", ulpi_dir_o, 0);
      tick();
      chk("rx_dir_cycles", dir_cnt, n + 3 + ((gap_at > 0) ? 1 : 0));
      chk("inj_ready_pulses", rdy_cnt, n);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] wb [8];
      logic [7:0] ib [4];
      logic [7:0] rd;
      int         nh;
      int         dirs;

      tick();
      tick();
      chk("reset_outputs", {ulpi_dir_o, ulpi_nxt_o, cap_valid_o, cap_last_o, inj_ready_o, ulpi_data_out_o}, 0);
      rst_i = 1'b0;
      tick();

      ulpi_data_in_i = 8'h43;
      ulpi_stp_i = 1'b1;
      tick();
      chk("idle_stp_ignored", {ulpi_dir_o, ulpi_nxt_o}, 0);
      ulpi_data_in_i = 8'h00;
      ulpi_stp_i = 1'b0;
      tick();

      wb = '{8'h84, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      link_write(wb, 2, nh);
      chk("regw_nxt_cycles", nh, 2);
      regr(8'hC4, rd, dirs);
      chk("regr_data", rd, 8'h5A);
      chk("regr_dir_cycles", dirs, 3);

      wb = '{8'h8F, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      link_write(wb, 2, nh);
      regr(8'hCF, rd, dirs);
      chk("regr_top_addr", rd, 8'hA5);
      wb = '{8'h94, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      link_write(wb, 2, nh);
      regr(8'hD4, rd, dirs);
      chk("regr_out_of_range", rd, 8'h00);

      exp_cap.push_back({1'b0, 8'h43});
      exp_cap.push_back({1'b0, 8'h11});
      exp_cap.push_back({1'b0, 8'h22});
      exp_cap.push_back({1'b1, 8'h33});
      wb = '{8'h43, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00};
      link_write(wb, 4, nh);
      chk("tx_nxt_after_stp", ulpi_nxt_o, 0);
      chk("tx3_stall_count", low_at.size(), 1);
      chk("tx3_stall_pos", low_at[0], 3);
      tick();
      tick();

      for (int i = 1; i <= 5; i++) exp_cap.push_back({1'b0, 8'(i)});
      exp_cap.push_front({1'b0, 8'h45});
      exp_cap[5] = {1'b1, 8'h05};
      wb = '{8'h45, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h00};
      link_write(wb, 6, nh);
      chk("tx5_stall_count", low_at.size(), 2);
      chk("tx5_stall_first", low_at[0], 3);
      chk("tx5_stall_second", low_at[1], 5);
      tick();
      tick();
      chk("tx_cap_drained", exp_cap.size(), 0);

      linestate_i = 2'b10;
      rxcmd_obs(8'h02);

      linestate_i = 2'b11;
      regr(8'hC4, rd, dirs);
      chk("regr_busy_data", rd, 8'h5A);
      chk("regr_busy_dir_cycles", dirs, 3);
      rxcmd_obs(8'h03);
      tick();

      ib = '{8'hC3, 8'h01, 8'h02, 8'h00};
      inject(ib, 3, 0, 2'b11);
      tick();
      ib = '{8'hAA, 8'hBB, 8'hCC, 8'h00};
      inject(ib, 3, 1, 2'b11);
      tick();

      ulpi_data_in_i = 8'h88;
      tick();
      tick();
      ulpi_data_in_i = 8'h77;
      chk("rst_pre_nxt", ulpi_nxt_o, 1);
      #2;
      rst_i = 1'b1;
      #1;
      chk("rst_async_dir_nxt", {ulpi_dir_o, ulpi_nxt_o}, 0);
      ulpi_data_in_i = 8'h00;
      tick();
      rst_i = 1'b0;
      tick();
      regr(8'hC8, rd, dirs);
      chk("regr_after_rst", rd, 8'h00);
      regr(8'hC4, rd, dirs);
      chk("regr_cleared_by_rst", rd, 8'h00);
      tick();

      chk("cap_queue_empty", exp_cap.size(), 0);
      chk("rx_queue_empty", exp_rx.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
